operand_loader: RTL and testbench

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/operand_loader.sv | 116 +++++++++++
 tb/tb_operand_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
// Operand entry for a small ALU: a debounced pushbutton steps through A, B and
// function capture, then holds the operand set until the consumer accepts it.
module operand_loader #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk_2,
    input  logic       reset_n,
    input  logic [2:0] sw_data,
    input  logic       enter,
    input  logic       cancel,
    input  logic       out_ready,
    output logic [2:0] op_a,
    output logic [2:0] op_b,
    output logic [1:0] op_f,
    output logic       out_valid,
    output logic [1:0] state_dbg,
    output logic [3:0] drop_cnt
);

    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_B   = 2'b01,
        S_F   = 2'b10,
        S_OUT = 2'b11
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CYCLES - 1);

    state_t     state;
    logic       enter_p0;
    logic       enter_p1;
    logic       deb;
    logic [3:0] cnt;
    logic       press_p2;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Stage 0/1: synchronizer; stage 2: debounce and rising-edge press pulse
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            enter_p0 <= 1'b0;
            enter_p1 <= 1'b0;
            deb      <= 1'b0;
            cnt      <= 4'd0;
            press_p2 <= 1'b0;
        end else begin
            enter_p0 <= enter;
            enter_p1 <= enter_p0;
            press_p2 <= 1'b0;
            if (enter_p1 == deb) begin
                cnt <= 4'd0;
            end else if (cnt == CNT_LAST) begin
                deb      <= enter_p1;
                cnt      <= 4'd0;
                press_p2 <= enter_p1;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    // Stage 3: operand capture FSM; cancel outranks every other event
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_A;
            op_a      <= 3'd0;
            op_b      <= 3'd0;
            op_f      <= 2'd0;
            out_valid <= 1'b0;
            drop_cnt  <= 4'd0;
        end else if (cancel) begin
            state     <= S_A;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_A: begin
                    if (press_p2) begin
                        op_a  <= sw_data;
                        state <= S_B;
                    end
                end
                S_B: begin
                    if (press_p2) begin
                        op_b  <= sw_data;
                        state <= S_F;
                    end
                end
                S_F: begin
                    if (press_p2) begin
                        op_f      <= sw_data[1:0];
                        state     <= S_OUT;
                        out_valid <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (press_p2) begin
                        drop_cnt <= sat_inc4(drop_cnt);
                    end
                    if (out_valid && out_ready) begin
                        state     <= S_A;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_A;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_operand_loader.sv
// Randomised and directed bench for operand_loader against a window-based
// debounce model and a stage-counter model of the operand sequence.
module tb_operand_loader;

    localparam int D = 4;

    logic       clk_2 = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] sw_data = 3'd0;
    logic       enter = 1'b0;
    logic       cancel = 1'b0;
    logic       out_ready = 1'b0;
    logic [2:0] op_a;
    logic [2:0] op_b;
    logic [1:0] op_f;
    logic       out_valid;
    logic [1:0] state_dbg;
    logic [3:0] drop_cnt;

    operand_loader #(.DEBOUNCE_CYCLES(D)) dut (
        .clk_2     (clk_2),
        .reset_n   (reset_n),
        .sw_data   (sw_data),
        .enter     (enter),
        .cancel    (cancel),
        .out_ready (out_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_f      (op_f),
        .out_valid (out_valid),
        .state_dbg (state_dbg),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk_2 = ~clk_2;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: raw enter history, debounced level, and operand stage
    bit         raw_q[$];
    bit         m_deb;
    bit         m_press;
    int         m_stage;
    logic [2:0] m_a;
    logic [2:0] m_b;
    logic [1:0] m_f;
    int         m_drop;

    function automatic void model_reset();
        raw_q.delete();
        for (int i = 0; i < D + 3; i++) raw_q.push_back(1'b0);
        m_deb   = 1'b0;
        m_press = 1'b0;
        m_stage = 0;
        m_a     = 3'd0;
        m_b     = 3'd0;
        m_f     = 2'd0;
        m_drop  = 0;
    endfunction

    always @(posedge clk_2) begin : model
        bit all_diff;
        if (reset_n) begin
            if (cancel) begin
                m_stage = 0;
            end else begin
                case (m_stage)
                    0: if (m_press) begin m_a = sw_data; m_stage = 1; end
                    1: if (m_press) begin m_b = sw_data; m_stage = 2; end
                    2: if (m_press) begin m_f = sw_data[1:0]; m_stage = 3; end
                    default: begin
                        if (m_press && m_drop < 15) m_drop++;
                        if (out_ready) m_stage = 0;
                    end
                endcase
            end
            // level accepted once the last D synchronized samples all disagree
            raw_q.push_front(enter);
            void'(raw_q.pop_back());
            all_diff = 1'b1;
            for (int k = 2; k < D + 2; k++)
                if (raw_q[k] == m_deb) all_diff = 1'b0;
            m_press = 1'b0;
            if (all_diff) begin
                m_deb   = ~m_deb;
                m_press = m_deb;
            end
        end
    end

    task automatic compare_all();
        check("state_dbg", 32'(state_dbg), 32'(m_stage));
        check("out_valid", 32'(out_valid), 32'(m_stage == 3));
        check("op_a", 32'(op_a), 32'(m_a));
        check("op_b", 32'(op_b), 32'(m_b));
        check("op_f", 32'(op_f), 32'(m_f));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    endtask

    task automatic step();
        @(posedge clk_2);
        @(negedge clk_2);
        compare_all();
    endtask

    task automatic press_op(input logic [2:0] v);
        sw_data = v;
        enter = 1'b1;
        repeat (D + 3) step();
        enter = 1'b0;
        repeat (D + 3) step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #2;
        compare_all();
        @(negedge clk_2);
        reset_n = 1'b1;
        compare_all();

        // first press captured exactly at edge 3+D
        sw_data = 3'b101;
        enter = 1'b1;
        repeat (D + 2) step();
        check("early_state", 32'(state_dbg), 32'd0);
        step();
        check("a_state", 32'(state_dbg), 32'd1);
        check("a_value", 32'(op_a), 32'd5);
        enter = 1'b0;
        repeat (8) step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check("cancel_b", 32'(state_dbg), 32'd0);

        // short pulses rejected
        repeat (5) begin
            enter = 1'b1;
            repeat (3) step();
            enter = 1'b0;
            repeat (3) step();
        end
        check("short_pulse", 32'(state_dbg), 32'd0);

        press_op(3'd2);
        press_op(3'd3);
        press_op(3'd1);
        check("full_valid", 32'(out_valid), 32'd1);
        check("full_a", 32'(op_a), 32'd2);
        check("full_b", 32'(op_b), 32'd3);
        check("full_f", 32'(op_f), 32'd1);
        repeat (10) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("xfer_valid", 32'(out_valid), 32'd0);
        check("xfer_state", 32'(state_dbg), 32'd0);

        // drop counter saturation
        press_op(3'd1);
        press_op(3'd2);
        press_op(3'd3);
        repeat (17) press_op(3'd7);
        check("drop_sat", 32'(drop_cnt), 32'd15);
        check("drop_a", 32'(op_a), 32'd1);
        check("drop_f", 32'(op_f), 32'd3);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // cancel coinciding with the press in S_F
        press_op(3'd4);
        press_op(3'd6);
        sw_data = 3'd2;
        enter = 1'b1;
        repeat (D + 2) step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        enter = 1'b0;
        check("cxp_state", 32'(state_dbg), 32'd0);
        check("cxp_f", 32'(op_f), 32'd3);
        check("cxp_drop", 32'(drop_cnt), 32'd15);
        repeat (8) step();

        // asynchronous reset in S_B
        press_op(3'd1);
        @(posedge clk_2);
        #3 reset_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (2) @(posedge clk_2);
        #4 reset_n = 1'b1;
        @(negedge clk_2);
        compare_all();
        check("rst_state", 32'(state_dbg), 32'd0);

        // randomized traffic
        repeat (600) begin
            if ($urandom_range(0, 5) == 0) enter = ~enter;
            cancel    = ($urandom_range(0, 39) == 0);
            out_ready = ($urandom_range(0, 3) == 0);
            sw_data   = 3'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
